// File: rtl/bcd_sched_pkg.sv
// Shared constants for the BCD converter scheduler: widths, limits,
// FSM state encoding and response path codes.
package bcd_sched_pkg;

    localparam int BIN_W = 32;
    localparam int BCD_W = 28;

    localparam logic [BIN_W-1:0] MAX_DEC = 32'd9999999;
    localparam logic [BCD_W-1:0] BCD_SAT = 28'h9999999;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ARB   = 3'd1;
    localparam logic [2:0] ST_CLR   = 3'd2;
    localparam logic [2:0] ST_START = 3'd3;
    localparam logic [2:0] ST_WAIT  = 3'd4;
    localparam logic [2:0] ST_RESP  = 3'd5;

    localparam logic [1:0] PATH_OK  = 2'd0;
    localparam logic [1:0] PATH_OVF = 2'd1;
    localparam logic [1:0] PATH_ERR = 2'd2;

endpackage

// File: rtl/bcd_conv_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request after ptr, wrapping.
// The pointer register itself lives in the scheduler.
module rr_arbiter #(
    parameter int NREQ = 4,
    localparam int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  grant,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    int               cand;
    logic [IDX_W-1:0] cand_idx;

    // Walk offsets from farthest to nearest so the nearest hit is written last.
    always_comb begin
        grant    = '0;
        idx      = '0;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int off = NREQ; off >= 1; off--) begin
            cand     = (int'(ptr) + off) % NREQ;
            cand_idx = IDX_W'(cand);
            if (req[cand_idx]) begin
                grant           = '0;
                grant[cand_idx] = 1'b1;
                idx             = cand_idx;
                found           = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bcd_conv_scheduler.sv
// Time-shares one binary-to-BCD converter between NREQ requesters with
// round-robin arbitration, overflow screening and a converter watchdog.
module bcd_conv_scheduler
    import bcd_sched_pkg::*;
#(
    parameter int               NREQ    = 4,
    parameter int               TIMEOUT = 100,
    parameter logic [BIN_W-1:0] MAX_DEC = bcd_sched_pkg::MAX_DEC
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NREQ-1:0]       req,
    input  logic [BIN_W*NREQ-1:0] req_data,
    output logic [NREQ-1:0]       resp_valid,
    output logic [BCD_W-1:0]      resp_bcd,
    output logic                  resp_ovf,
    output logic                  resp_err,
    output logic                  busy,
    output logic                  conv_reset_n,
    output logic                  conv_enable,
    output logic [BIN_W-1:0]      conv_binary,
    input  logic [BCD_W-1:0]      conv_bcd,
    input  logic                  conv_valid,
    output logic [2:0]            dbg_state
);

    // Handshake: a requester holds req[k] high with stable req_data until
    // resp_valid[k] pulses for one cycle; resp_* fields are valid in that cycle.

    localparam int IDX_W = $clog2(NREQ);
    localparam int TMR_W = $clog2(TIMEOUT);

    logic [2:0]       state;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] gnt_idx;
    logic [BIN_W-1:0] op_reg;
    logic [TMR_W-1:0] timer;

    logic [NREQ-1:0]  arb_grant;
    logic [IDX_W-1:0] arb_idx;
    logic             arb_found;
    logic [BIN_W-1:0] sel_data;
    logic             sel_ovf;

    logic             enter_resp;
    logic [1:0]       resp_path;
    logic [IDX_W-1:0] resp_owner;
    logic [NREQ-1:0]  owner_onehot;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req   (req),
        .ptr   (rr_ptr),
        .grant (arb_grant),
        .idx   (arb_idx),
        .found (arb_found)
    );

    assign sel_data = req_data[arb_idx*BIN_W +: BIN_W];
    assign sel_ovf  = (sel_data > MAX_DEC);

    // Overflow responses skip the converter entirely, straight from ARB.
    always_comb begin
        enter_resp = 1'b0;
        resp_path  = PATH_OK;
        resp_owner = gnt_idx;
        if (state == ST_ARB && arb_found && sel_ovf) begin
            enter_resp = 1'b1;
            resp_path  = PATH_OVF;
            resp_owner = arb_idx;
        end else if (state == ST_WAIT) begin
            if (conv_valid) begin
                enter_resp = 1'b1;
            end else if (timer == TMR_W'(TIMEOUT - 1)) begin
                enter_resp = 1'b1;
                resp_path  = PATH_ERR;
            end
        end
    end

    assign owner_onehot = NREQ'(1) << resp_owner;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            rr_ptr      <= IDX_W'(NREQ - 1);
            gnt_idx     <= '0;
            op_reg      <= '0;
            timer       <= '0;
            conv_enable <= 1'b0;
            resp_valid  <= '0;
            resp_bcd    <= '0;
            resp_ovf    <= 1'b0;
            resp_err    <= 1'b0;
        end else begin
            resp_valid <= '0;
            if (enter_resp) begin
                resp_valid <= owner_onehot;
                case (resp_path)
                    PATH_OVF: begin
                        resp_bcd <= BCD_SAT;
                        resp_ovf <= 1'b1;
                        resp_err <= 1'b0;
                    end
                    PATH_ERR: begin
                        resp_bcd <= '0;
                        resp_ovf <= 1'b0;
                        resp_err <= 1'b1;
                    end
                    default: begin
                        resp_bcd <= conv_bcd;
                        resp_ovf <= 1'b0;
                        resp_err <= 1'b0;
                    end
                endcase
            end

            case (state)
                ST_IDLE: begin
                    if (|req) state <= ST_ARB;
                end
                ST_ARB: begin
                    if (arb_found) begin
                        gnt_idx <= arb_idx;
                        rr_ptr  <= arb_idx;
                        op_reg  <= sel_data;
                        state   <= sel_ovf ? ST_RESP : ST_CLR;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_CLR: begin
                    conv_enable <= 1'b1;
                    timer       <= '0;
                    state       <= ST_START;
                end
                ST_START: begin
                    conv_enable <= 1'b0;
                    timer       <= '0;
                    state       <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (enter_resp) state <= ST_RESP;
                    else            timer <= timer + 1'b1;
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // The converter's DONE flag is sticky; CLR is the only way to rearm it.
    assign conv_reset_n = reset_n & (state != ST_CLR);
    assign conv_binary  = op_reg;
    assign busy         = (state != ST_IDLE);
    assign dbg_state    = state;

endmodule
